// File: rtl/mem_bus_lsu.sv
// Memory-stage load/store unit: turns one execute-stage memory request into a
// single data-bus transaction, aligns store data onto byte lanes, and returns
// sign/zero-extended load data. The pipeline is stalled until the access ends.
//
// Bus handshake: bus_req_o rises with bus_addr_o/bus_we_o/bus_sel_o/bus_wdata_o
// and all of them stay stable until the first cycle bus_ack_i=1 is sampled;
// bus_err_i and bus_rdata_i are meaningful only in that ack cycle. The request
// is withdrawn at the ack edge, on timeout, or on reset.
module mem_bus_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_we_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        err_o,
    output logic        misalign_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic [3:0]  op_q;
    logic [1:0]  addr_lo_q;

    logic        is_byte, is_half, is_word, is_store, op_valid, misaligned;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d;
    logic        start, misal_start, req_ack, req_timeout;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;
    logic        op_q_is_load;

    assign state_o = state_q;

    // Decode the incoming request: size, direction, validity, lanes, write data.
    // A code whose direction disagrees with mem_we_i is treated as no request.
    always_comb begin
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        is_store = 1'b0;
        op_valid = 1'b1;
        case (mem_op_i)
            OP_LB, OP_LBU: is_byte = 1'b1;
            OP_LH, OP_LHU: is_half = 1'b1;
            OP_LW:         is_word = 1'b1;
            OP_SB:         begin is_byte = 1'b1; is_store = 1'b1; end
            OP_SH:         begin is_half = 1'b1; is_store = 1'b1; end
            OP_SW:         begin is_word = 1'b1; is_store = 1'b1; end
            default:       op_valid = 1'b0;
        endcase
        if (mem_we_i != is_store) begin
            op_valid = 1'b0;
        end
        misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
        sel_d   = 4'b1111;
        wdata_d = 32'd0;
        if (is_byte) begin
            sel_d = 4'b0001 << mem_addr_i[1:0];
        end else if (is_half) begin
            sel_d = 4'b0011 << {mem_addr_i[1], 1'b0};
        end
        if (is_store) begin
            if (is_byte) begin
                wdata_d = {4{mem_data_i[7:0]}};
            end else if (is_half) begin
                wdata_d = {2{mem_data_i[15:0]}};
            end else begin
                wdata_d = mem_data_i;
            end
        end
    end

    // Extract and extend the addressed lane of the returned read word.
    always_comb begin
        byte_v       = 8'(bus_rdata_i >> {addr_lo_q, 3'b000});
        half_v       = 16'(bus_rdata_i >> {addr_lo_q[1], 4'b0000});
        op_q_is_load = (op_q >= OP_LB) && (op_q <= OP_LHU);
        case (op_q)
            OP_LB:   load_ext = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_ext = {24'd0, byte_v};
            OP_LH:   load_ext = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_ext = {16'd0, half_v};
            default: load_ext = bus_rdata_i;
        endcase
    end

    // Next-state logic, stall and transaction control strobes.
    always_comb begin
        state_d     = state_q;
        stall_o     = 1'b0;
        start       = 1'b0;
        misal_start = 1'b0;
        req_ack     = 1'b0;
        req_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    stall_o = 1'b1;
                    state_d = DONE;
                    if (misaligned) begin
                        misal_start = 1'b1;
                    end else begin
                        start   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_o = 1'b1;
                // An ack in the limit cycle wins over the timeout.
                if (bus_ack_i) begin
                    req_ack = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == TO_LIMIT) begin
                    req_timeout = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus outputs, wait counter, load result and completion pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= 32'd0;
            bus_sel_o     <= 4'd0;
            bus_wdata_o   <= 32'd0;
            rdata_o       <= 32'd0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            misalign_o    <= 1'b0;
            cnt_q         <= 16'd0;
            op_q          <= 4'd0;
            addr_lo_q     <= 2'd0;
        end else begin
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
            misalign_o    <= 1'b0;
            if (start) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= is_store;
                bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                bus_sel_o   <= sel_d;
                bus_wdata_o <= wdata_d;
                op_q        <= mem_op_i;
                addr_lo_q   <= mem_addr_i[1:0];
                cnt_q       <= 16'd0;
            end
            if (misal_start) begin
                err_o      <= 1'b1;
                misalign_o <= 1'b1;
            end
            if (req_ack) begin
                bus_req_o <= 1'b0;
                if (bus_err_i) begin
                    err_o <= 1'b1;
                end else if (op_q_is_load) begin
                    rdata_o       <= load_ext;
                    rdata_valid_o <= 1'b1;
                end
            end
            if (req_timeout) begin
                bus_req_o <= 1'b0;
                err_o     <= 1'b1;
            end
            if ((state_q == REQ) && !req_ack && !req_timeout) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_lsu.sv
// Directed bench for mem_bus_lsu with a load-result scoreboard.
module tb_mem_bus_lsu;

  localparam int TIMEOUT_TB = 4;

  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] LB  = 4'd1;
  localparam logic [3:0] LH  = 4'd2;
  localparam logic [3:0] LW  = 4'd3;
  localparam logic [3:0] LBU = 4'd4;
  localparam logic [3:0] LHU = 4'd5;
  localparam logic [3:0] SB  = 4'd6;
  localparam logic [3:0] SH  = 4'd7;
  localparam logic [3:0] SW  = 4'd8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  mem_op_i = 4'd0;
  logic [31:0] mem_addr_i = 32'd0;
  logic [31:0] mem_data_i = 32'd0;
  logic        mem_we_i = 1'b0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        err_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'd0;
  logic [1:0]  state_o;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd = 32'd0;

  mem_bus_lsu #(.TIMEOUT(TIMEOUT_TB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_we_i(mem_we_i), .stall_o(stall_o), .rdata_o(rdata_o),
    .rdata_valid_o(rdata_valid_o), .err_o(err_o), .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i), .state_o(state_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Aligned access; n_wait<0 means the bus never acks.
  task automatic access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input int n_wait, input logic [31:0] rd,
                        input logic berr, input logic [3:0] exp_sel,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    logic is_st, timeout, ld_ok;
    int stall_cnt, req_cycles;
    is_st = (op >= SB);
    timeout = (n_wait < 0);
    ld_ok = !is_st && !berr && !timeout;
    if (ld_ok) exp_q.push_back(exp_rdata);
    mem_op_i = op; mem_addr_i = addr; mem_data_i = data; mem_we_i = is_st;
    stall_cnt = 0;
    req_cycles = timeout ? TIMEOUT_TB : n_wait + 1;
    @(negedge clk_i);
    chk({tag, "_idle_req"}, 32'(bus_req_o), 32'd0);
    if (stall_o) stall_cnt++;
    for (int i = 0; i < req_cycles; i++) begin
      next_cycle();
      bus_rdata_i = $urandom;
      if (!timeout && i == n_wait) begin
        bus_ack_i = 1'b1; bus_err_i = berr; bus_rdata_i = rd;
      end
      @(negedge clk_i);
      chk({tag, "_req"}, 32'(bus_req_o), 32'd1);
      chk({tag, "_addr"}, bus_addr_o, {addr[31:2], 2'b00});
      chk({tag, "_sel"}, 32'(bus_sel_o), 32'(exp_sel));
      chk({tag, "_wdata"}, bus_wdata_o, exp_wdata);
      chk({tag, "_we"}, 32'(bus_we_o), 32'(is_st));
      if (stall_o) stall_cnt++;
    end
    next_cycle();
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = $urandom;
    mem_op_i = NOP; mem_we_i = 1'b0; mem_addr_i = $urandom; mem_data_i = $urandom;
    @(negedge clk_i);
    chk({tag, "_done_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_done_req"}, 32'(bus_req_o), 32'd0);
    chk({tag, "_done_valid"}, 32'(rdata_valid_o), 32'(ld_ok));
    chk({tag, "_done_err"}, 32'(err_o), 32'(berr || timeout));
    chk({tag, "_done_misal"}, 32'(misalign_o), 32'd0);
    if (rdata_valid_o && exp_q.size() > 0) begin
      chk({tag, "_rdata"}, rdata_o, exp_q.pop_front());
      last_rd = exp_rdata;
    end else begin
      chk({tag, "_rdata_hold"}, rdata_o, last_rd);
    end
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(req_cycles + 1));
    next_cycle();
    @(negedge clk_i);
    chk({tag, "_after_valid"}, 32'(rdata_valid_o), 32'd0);
    chk({tag, "_after_err"}, 32'(err_o), 32'd0);
    chk({tag, "_after_stall"}, 32'(stall_o), 32'd0);
    next_cycle();
  endtask

  task automatic misaligned(input string tag, input logic [3:0] op, input logic [31:0] addr);
    mem_op_i = op; mem_addr_i = addr; mem_data_i = $urandom; mem_we_i = (op >= SB);
    @(negedge clk_i);
    chk({tag, "_stall"}, 32'(stall_o), 32'd1);
    chk({tag, "_req0"}, 32'(bus_req_o), 32'd0);
    next_cycle();
    mem_op_i = NOP; mem_we_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_err"}, 32'(err_o), 32'd1);
    chk({tag, "_misal"}, 32'(misalign_o), 32'd1);
    chk({tag, "_done_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_req1"}, 32'(bus_req_o), 32'd0);
    chk({tag, "_valid"}, 32'(rdata_valid_o), 32'd0);
    next_cycle();
    @(negedge clk_i);
    chk({tag, "_err_clr"}, 32'(err_o), 32'd0);
    chk({tag, "_misal_clr"}, 32'(misalign_o), 32'd0);
    chk({tag, "_req2"}, 32'(bus_req_o), 32'd0);
    next_cycle();
  endtask

  initial begin
    // reset
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_we", 32'(bus_we_o), 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_sel", 32'(bus_sel_o), 32'd0);
    chk("rst_wdata", bus_wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_valid", 32'(rdata_valid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_misal", 32'(misalign_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    next_cycle();
    rst_i = 1'b1;
    next_cycle();

    // stores
    access("sw", SW, 32'h100, 32'hDEADBEEF, 2, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
    access("sb", SB, 32'h203, 32'h000000A5, 0, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0);
    access("sb0", SB, 32'h200, 32'h1234565A, 1, 32'h0, 1'b0, 4'b0001, 32'h5A5A5A5A, 32'h0);
    access("sh", SH, 32'h406, 32'hFFFF1234, 0, 32'h0, 1'b0, 4'b1100, 32'h12341234, 32'h0);

    // loads
    access("lb", LB, 32'h302, $urandom, 0, 32'h8081F0F1, 1'b0, 4'b0100, 32'h0, 32'hFFFFFF81);
    access("lbu", LBU, 32'h302, $urandom, 1, 32'h8081F0F1, 1'b0, 4'b0100, 32'h0, 32'h00000081);
    access("lh", LH, 32'h302, $urandom, 0, 32'h8081F0F1, 1'b0, 4'b1100, 32'h0, 32'hFFFF8081);
    access("lhu", LHU, 32'h302, $urandom, 2, 32'h8081F0F1, 1'b0, 4'b1100, 32'h0, 32'h00008081);
    access("lw", LW, 32'h300, $urandom, 0, 32'h8081F0F1, 1'b0, 4'b1111, 32'h0, 32'h8081F0F1);
    access("lb1", LB, 32'h301, $urandom, 0, 32'h12347F56, 1'b0, 4'b0010, 32'h0, 32'h0000007F);
    access("lh0", LH, 32'h300, $urandom, 0, 32'h0000F0F1, 1'b0, 4'b0011, 32'h0, 32'hFFFFF0F1);

    // misalignment
    misaligned("lw_mis", LW, 32'h401);
    misaligned("sh_mis", SH, 32'h405);

    // timeout, bus error, ack at the limit cycle
    access("lw_to", LW, 32'h500, $urandom, -1, 32'h0, 1'b0, 4'b1111, 32'h0, 32'h0);
    access("lw_berr", LW, 32'h504, $urandom, 0, 32'hCAFEF00D, 1'b1, 4'b1111, 32'h0, 32'h0);
    access("lw_lim", LW, 32'h508, $urandom, TIMEOUT_TB - 1, 32'h13572468, 1'b0, 4'b1111, 32'h0, 32'h13572468);

    // reset in the second REQ cycle
    mem_op_i = LW; mem_addr_i = 32'h600; mem_we_i = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    chk("mid_req_before", 32'(bus_req_o), 32'd1);
    rst_i = 1'b0; mem_op_i = NOP;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("mid_req_after", 32'(bus_req_o), 32'd0);
    chk("mid_state", 32'(state_o), 32'd0);
    chk("mid_valid", 32'(rdata_valid_o), 32'd0);
    chk("mid_err", 32'(err_o), 32'd0);
    rst_i = 1'b1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h87654321;
    next_cycle();
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    chk("late_valid", 32'(rdata_valid_o), 32'd0);
    chk("late_err", 32'(err_o), 32'd0);
    chk("late_req", 32'(bus_req_o), 32'd0);
    next_cycle();
    @(negedge clk_i);
    chk("late_valid2", 32'(rdata_valid_o), 32'd0);
    chk("late_err2", 32'(err_o), 32'd0);
    chk("late_rdata", rdata_o, 32'd0);
    chk("late_state", 32'(state_o), 32'd0);

    // final report
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_lsu.md
Name: mem_bus_lsu

Overview:
Memory-stage load/store responder. It consumes the execute stage's memory request (op code, address, store data) and runs one transaction on the data bus. It aligns store data and generates byte lanes, then extracts and sign- or zero-extends load data. The pipeline is stalled until the access completes.

Parameters:
TIMEOUT, 255, bus cycles to wait for bus_ack_i before aborting with an error; range 2..65535.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-low
mem_op_i  in  4  access code from execute: NOP=0 LB=1 LH=2 LW=3 LBU=4 LHU=5 SB=6 SH=7 SW=8 (defines.v values)
mem_addr_i  in  32  byte address
mem_data_i  in  32  store data; value in low bits
mem_we_i  in  1  1 for stores; must agree with mem_op_i
stall_o  out  1  hold upstream pipeline; combinational
rdata_o  out  32  extended load result; registered
rdata_valid_o  out  1  one-cycle pulse when rdata_o holds a new load result
err_o  out  1  one-cycle pulse on bus error, timeout or misalignment
misalign_o  out  1  one-cycle pulse, qualifies err_o as a misalignment
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write
bus_addr_o  out  32  word address, mem_addr_i with bits [1:0] forced to 0
bus_sel_o  out  4  byte lane enables
bus_wdata_o  out  32  lane-replicated store data
bus_ack_i  in  1  bus completion
bus_err_i  in  1  bus error; valid only when bus_ack_i=1
bus_rdata_i  in  32  read word; valid when bus_ack_i=1

Behaviour:
- Reset (rst_i=0 at a clock edge): state=IDLE, timeout counter=0, and these outputs go to 0: bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o, rdata_o, rdata_valid_o, err_o, misalign_o. Reset mid-transaction drops bus_req_o at that edge with no completion pulse; any late ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE, mem_op_i=NOP or an undefined code: stay in IDLE; stall_o=0.
- IDLE, valid op and aligned: stall_o=1. At the edge, latch bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o and the op; set bus_req_o=1; go to REQ.
- IDLE, valid op and misaligned: stall_o=1. Go to DONE with err_o=1 and misalign_o=1; no bus request is issued.
- Misalignment is defined as:
  - LH, LHU or SH with addr[0]=1;
  - LW or SW with addr[1:0] not equal to 0.
- REQ: stall_o=1. Bus outputs are held stable until ack.
  - On bus_ack_i=1: bus_req_o=0 at the edge, go to DONE.
    - Load with bus_err_i=0: capture the extended data into rdata_o and pulse rdata_valid_o.
    - bus_err_i=1: pulse err_o; rdata_o is unchanged.
  - The counter increments each REQ cycle without ack. When it reaches TIMEOUT-1: bus_req_o=0, go to DONE, pulse err_o.
  - Counter clears on entry to REQ.
  - An ack in the same cycle the counter hits its limit counts as success.
- DONE: stall_o=0 so the pipeline advances. Pulse outputs are high in this cycle only. Return to IDLE unconditionally; inputs are ignored.
- Minimum access is 3 cycles (IDLE, REQ, DONE) with a zero-wait ack.
- bus_sel_o:
  - byte access: 4'b0001 << addr[1:0];
  - halfword access: 4'b0011 << {addr[1],1'b0};
  - word access: 4'b1111.
- bus_wdata_o:
  - SB: {4{data[7:0]}};
  - SH: {2{data[15:0]}};
  - SW: data.
  - For loads, bus_wdata_o=0.
- Load extraction from bus_rdata_i:
  - byte = rdata[8*addr[1:0] +: 8];
  - half = rdata[16*addr[1] +: 16].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Stores never pulse rdata_valid_o.

Test Plan:
- SW addr=0x100 data=0xDEADBEEF, ack after 2 wait cycles -> bus_addr_o=0x100, sel=1111, wdata=0xDEADBEEF, we=1; stall_o high 4 cycles; no rdata_valid_o.
- SB addr=0x203 data=0x000000A5, immediate ack -> bus_addr_o=0x200, sel=1000, wdata=0xA5A5A5A5; access takes 3 cycles.
- LB, LBU, LH, LHU, LW at addr 0x302 with bus_rdata_i=0x8081F0F1 ->
  - LB 0xFFFFFF81;
  - LBU 0x00000081;
  - LH 0xFFFF8081;
  - LHU 0x00008081;
  - LW at 0x300 gives 0x8081F0F1.
- LW addr=0x401 and SH addr=0x405 -> no bus_req_o; err_o=misalign_o=1 for one cycle; stall_o released after 2 cycles.
- TIMEOUT=4 override, LW with no ack -> bus_req_o drops after 4 REQ cycles; err_o pulses; rdata_o unchanged. A following LW with ack plus bus_err_i=1 -> err_o=1, rdata_valid_o=0.
- rst_i=0 in the second REQ cycle of a LW -> next edge bus_req_o=0 and state=IDLE; an ack arriving after reset produces no rdata_valid_o or err_o.
